// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg
//   Shared definitions for the boot-time instruction loader and the CPU top
//   that reads the same instruction memory.
//   - IM_ADDR_W     : instruction-memory word-address width (shared with CPU)
//   - SYNC_BYTE_DEF : default frame start marker
//   - state_t       : loader FSM state encoding
package inst_loader_pkg;

  localparam int         IM_ADDR_W     = 9;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

endpackage

// File: rtl/inst_loader_pack.sv
// inst_loader_pack
//   Byte-to-word assembler: places successive bytes into a 32-bit word,
//   least-significant byte first, using a 2-bit byte index.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : restart assembly at byte 0 (start of a new image)
//   shift_en    : accept byte_in into the current lane
//   byte_in     : incoming byte
//   word        : assembled word (registered)
//   idx         : lane the next byte will land in
//   last_byte   : high when the next accepted byte completes the word
module inst_loader_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  idx,
  output logic        last_byte
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      idx  <= '0;
    end else if (shift_en) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 2'd1;  // wraps modulo 4
    end
  end

  assign last_byte = (idx == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// inst_loader
//   Boot-time instruction loader. Receives a framed byte stream
//   (SYNC, LEN_LO, LEN_HI, 4*N data bytes [, XOR checksum]), assembles
//   little-endian words and writes them to instruction memory from word
//   address 0. Holds the CPU in reset until a complete image is written.
// Build option:
//   INST_LOADER_CSUM_EN - frame carries a trailing XOR checksum of all data
//                         bytes; mismatch ends in ERR.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_data, rx_valid   : incoming byte stream
//   rx_ready            : loader can accept a byte
//   im_wen, im_addr,    : instruction-memory write port (one pulse per word)
//   im_din
//   cpu_rst_n           : CPU reset, released only in DONE
//   busy, done, err     : load status
//   dbg_state           : current FSM state for observation
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready;
// rx_ready depends only on registered state, never on rx_valid.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int         ADDR_W    = IM_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_wen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  state_t            state, next_state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       len_n;
  logic              len_bad;
  logic              last_word;
  logic              xfer;
  logic              is_sync;
  logic              last_byte;
  logic [1:0]        pack_idx;
`ifdef INST_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer    = rx_valid && rx_ready;
  assign is_sync = (rx_data == SYNC_BYTE);

  // Word count as it will be once LEN_HI is accepted.
  assign len_n   = {rx_data, len_lo};
  assign len_bad = (len_n == 16'd0) || (32'(len_n) > MAX_WORDS);

  // Word being written is the last one when addr+1 reaches the count.
  assign last_word = ((17'(addr) + 17'd1) == {1'b0, len});

  inst_loader_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       ((state == ST_LEN_HI) && xfer),
    .shift_en  ((state == ST_DATA) && xfer),
    .byte_in   (rx_data),
    .word      (im_din),
    .idx       (pack_idx),
    .last_byte (last_byte)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (xfer && is_sync) next_state = ST_LEN_LO;
      ST_LEN_LO: if (xfer)            next_state = ST_LEN_HI;
      ST_LEN_HI: if (xfer)            next_state = len_bad ? ST_ERR : ST_DATA;
      ST_DATA:   if (xfer && last_byte) next_state = ST_WRITE;
      ST_WRITE: begin
        if (last_word) begin
`ifdef INST_LOADER_CSUM_EN
          next_state = ST_CSUM;
`else
          next_state = ST_DONE;
`endif
        end else begin
          next_state = ST_DATA;
        end
      end
`ifdef INST_LOADER_CSUM_EN
      ST_CSUM:   if (xfer) next_state = (rx_data == csum) ? ST_DONE : ST_ERR;
`else
      ST_CSUM:   next_state = ST_IDLE;  // not reachable without checksum
`endif
      ST_DONE,
      ST_ERR:    if (xfer && is_sync) next_state = ST_LEN_LO;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output decode (registered state only)
  always_comb begin
    rx_ready  = (state != ST_WRITE);
    im_wen    = (state == ST_WRITE);
    busy      = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                (state == ST_DATA)   || (state == ST_WRITE)  ||
                (state == ST_CSUM);
    cpu_rst_n = (state == ST_DONE);
    done      = (state == ST_DONE);
    err       = (state == ST_ERR);
    dbg_state = state;
  end

  assign im_addr = addr;

  // Length capture and address counter. The address is not advanced past
  // the final word, so it stays in range even for a full-size image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo <= '0;
      len    <= '0;
      addr   <= '0;
    end else begin
      case (state)
        ST_LEN_LO: if (xfer) len_lo <= rx_data;
        ST_LEN_HI: if (xfer) begin
          len  <= len_n;
          addr <= '0;
        end
        ST_WRITE:  if (!last_word) addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef INST_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if ((state == ST_LEN_HI) && xfer) begin
      csum <= '0;
    end else if ((state == ST_DATA) && xfer) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time instruction loader: the write side of the instruction memory that the CPU core only reads. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from word address 0. It holds the CPU in reset while loading and releases it once a complete, valid image has been written.

## Interface

Parameters:
- ADDR_W, 9, instruction-memory word-address width; maximum image size is 2^ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready.
- im_wen  out  1  instruction-memory write enable, one-cycle pulse per word.
- im_addr  out  ADDR_W  word address.
- im_din  out  32  write data.
- cpu_rst_n  out  1  CPU reset, active-low; high only in DONE.
- busy  out  1  load in progress (states LEN_LO through CSUM).
- done  out  1  image loaded.
- err  out  1  frame error.

## Operation

- Frame: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes (LSB first per word), then a checksum byte when CSUM is enabled.
- States:
  - IDLE: waits for a byte equal to SYNC_BYTE, then goes to LEN_LO. Other bytes are consumed and discarded.
  - LEN_LO: stores the low count byte.
  - LEN_HI: stores the high count byte. N==0 or N>2^ADDR_W goes to ERR; otherwise goes to DATA and clears the address and byte index.
  - DATA: shifts the byte into bits [8*idx+7:8*idx] and increments idx modulo 4. When idx==3 it goes to WRITE.
  - WRITE: rx_ready=0, im_wen=1 for exactly this cycle. Afterwards the address increments. When the last word has been written, go to CSUM if enabled, else DONE; otherwise return to DATA.
  - CSUM: compares the byte against the XOR of all data bytes. Match goes to DONE; mismatch goes to ERR.
  - DONE: cpu_rst_n=1, done=1.
  - ERR: err=1, cpu_rst_n=0.
- In DONE or ERR, a SYNC_BYTE restarts the load (goes to LEN_LO). In that case cpu_rst_n falls and done/err clear the next cycle. Other bytes are discarded.
- rx_ready=1 in every state except WRITE.
- Address arithmetic: im_addr is an ADDR_W-bit counter. Its wrap is unreachable because of the N bound.
- N==2^ADDR_W is legal; the final write goes to address 2^ADDR_W-1.
- Memory contents beyond N are untouched.

## Timing

- Reset values: state=IDLE, rx_ready=1, im_wen=0, im_addr=0, im_din=0, cpu_rst_n=0, busy=0, done=0, err=0.
- All outputs are registered or decoded from registered state. There are no combinational paths from rx_* to any output.
- Write latency: im_wen is asserted in the cycle after the handshake of a word's 4th byte. im_addr and im_din are stable in that cycle.
- Throughput: at most 1 byte per cycle; one bubble per word (WRITE).
- cpu_rst_n rises in the first cycle in DONE:
  - non-CSUM: the cycle after the final WRITE;
  - CSUM: the cycle after the checksum handshake.
- Reset asserted mid-load returns to IDLE immediately. The partial image remains in memory and the CPU stays in reset.
- rx_valid low for any number of cycles stalls in place with no timeout.

## Configuration

- INST_LOADER_CSUM_EN defined: the frame carries a trailing XOR checksum byte; the CSUM state and the 8-bit accumulator exist; a mismatch leads to ERR.
- INST_LOADER_CSUM_EN undefined: no checksum byte; the last WRITE goes directly to DONE; CSUM logic is removed; err is asserted only for a bad length.

## Structure

- Shared package holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR);
  - the SYNC_BYTE default;
  - the instruction-memory word-address width constant (9), shared with the CPU top.
- No sub-module is required. The byte-to-word assembler (shift register plus 2-bit index) may be split out as inst_loader_pack if reused.

## Test plan

- Reset, no input → cpu_rst_n=0, rx_ready=1, done=0, err=0, im_wen never asserted.
- Frame A5 01 00 78 56 34 12 (CSUM off) → a single im_wen with im_addr=0, im_din=32'h12345678; cpu_rst_n=1 two cycles after the last byte handshake.
- N=3 with rx_valid toggling every other cycle → three writes to addresses 0, 1, 2 with correct data; rx_ready=0 only in the WRITE cycles.
- Length 00 00, then separately length 01 02 (N=513) → ERR, err=1, no writes; a following A5 01 00 ... frame loads cleanly and err clears.
- CSUM on, frame A5 01 00 01 02 04 08 0F → done. Same frame with checksum 0E → the word is still written, err=1, cpu_rst_n stays 0.
- While in DONE, send A5 → cpu_rst_n falls the next cycle; rst_n pulsed mid-DATA → IDLE, im_wen stays 0.
